// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR front-end loader: state encoding, LED phase codes
// and the default operand width.
package lfsr_pkg;

    localparam int unsigned LFSR_WIDTH = 8;
    localparam int unsigned STATE_W    = 3;
    localparam int unsigned PHASE_W    = 2;

    typedef logic [STATE_W-1:0] state_t;
    typedef logic [PHASE_W-1:0] phase_t;

    localparam state_t ST_LOAD_TAPS  = 3'd0;
    localparam state_t ST_LOAD_SEED  = 3'd1;
    localparam state_t ST_LOAD_COUNT = 3'd2;
    localparam state_t ST_FIRE       = 3'd3;
    localparam state_t ST_RUN        = 3'd4;

    localparam phase_t PH_TAPS  = 2'd0;
    localparam phase_t PH_SEED  = 2'd1;
    localparam phase_t PH_COUNT = 2'd2;
    localparam phase_t PH_RUN   = 2'd3;

    // LED phase shown for a given controller state; FIRE and RUN share one code.
    function automatic phase_t phase_of(input state_t s);
        phase_t p;
        case (s)
            ST_LOAD_TAPS:  p = PH_TAPS;
            ST_LOAD_SEED:  p = PH_SEED;
            ST_LOAD_COUNT: p = PH_COUNT;
            default:       p = PH_RUN;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/lfsr_input_loader_if.sv
// User-facing bundle of the loader: raw button/switches and busy in, captured operands,
// start request and status out.
interface lfsr_input_loader_if #(
    parameter int unsigned WIDTH = lfsr_pkg::LFSR_WIDTH
) ();

    logic                 btn;
    logic [WIDTH-1:0]     sw;
    logic                 busy;
    logic                 start;
    logic [WIDTH-1:0]     taps;
    logic [WIDTH-1:0]     seed;
    logic [WIDTH-1:0]     seq_num;
    lfsr_pkg::phase_t     phase;
    logic                 load_err;

    modport master (
        output btn, sw, busy,
        input  start, taps, seed, seq_num, phase, load_err
    );

    modport slave (
        input  btn, sw, busy,
        output start, taps, seed, seq_num, phase, load_err
    );

endinterface

// File: rtl/lfsr_input_loader_button_debouncer.sv
// Push-button conditioner: 2-FF synchroniser, optional stability counter
// (LOADER_DEBOUNCE_EN) and rising-edge detector producing a one-cycle press.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    logic r_btn_meta;
    logic r_btn_s;
    logic r_btn_clean;
    logic r_btn_clean_d;

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
        $error("button_debouncer: DEBOUNCE_CYCLES must be at least 2");
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_btn_meta <= 1'b0;
            r_btn_s    <= 1'b0;
        end else begin
            r_btn_meta <= btn;
            r_btn_s    <= r_btn_meta;
        end
    end

`ifdef LOADER_DEBOUNCE_EN
    localparam int unsigned        CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    // Accept a new level only after it has disagreed with the clean level long enough.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_btn_clean <= 1'b0;
        end else if (r_btn_s == r_btn_clean) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt       <= '0;
            r_btn_clean <= r_btn_s;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_btn_clean <= 1'b0;
        end else begin
            r_btn_clean <= r_btn_s;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_btn_clean_d <= 1'b0;
        end else begin
            r_btn_clean_d <= r_btn_clean;
        end
    end

    assign press = r_btn_clean & ~r_btn_clean_d;

endmodule

// File: rtl/lfsr_input_loader.sv
// Front-end loader for the LFSR core: three button-confirmed operand loads, then a
// start/busy handshake. Button debounce counter is enabled by LOADER_DEBOUNCE_EN.
module lfsr_input_loader
    import lfsr_pkg::*;
#(
    parameter int unsigned WIDTH           = LFSR_WIDTH,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    lfsr_input_loader_if.slave bus
);

    logic [WIDTH-1:0] r_sw_meta;
    logic [WIDTH-1:0] r_sw_s;
    logic             w_press;

    state_t           r_state;
    state_t           w_next_state;

    logic             w_in_load;
    logic             w_accept;
    logic             w_cap_taps;
    logic             w_cap_seed;
    logic             w_cap_count;
    logic             w_load_err_nxt;
    logic             w_start_nxt;
    phase_t           w_phase_nxt;

    logic [WIDTH-1:0] r_taps;
    logic [WIDTH-1:0] r_seed;
    logic [WIDTH-1:0] r_seq_num;
    logic             r_start;
    logic             r_load_err;
    phase_t           r_phase;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_button_debouncer (
        .clk   (clk),
        .reset (reset),
        .btn   (bus.btn),
        .press (w_press)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sw_meta <= '0;
            r_sw_s    <= '0;
        end else begin
            r_sw_meta <= bus.sw;
            r_sw_s    <= r_sw_meta;
        end
    end

    assign w_in_load = (r_state == ST_LOAD_TAPS) || (r_state == ST_LOAD_SEED) ||
                       (r_state == ST_LOAD_COUNT);
    assign w_accept  = w_press && w_in_load && (r_sw_s != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_LOAD_TAPS;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_LOAD_TAPS:  if (w_accept)  w_next_state = ST_LOAD_SEED;
            ST_LOAD_SEED:  if (w_accept)  w_next_state = ST_LOAD_COUNT;
            ST_LOAD_COUNT: if (w_accept)  w_next_state = ST_FIRE;
            ST_FIRE:       if (bus.busy)  w_next_state = ST_RUN;
            ST_RUN:        if (!bus.busy) w_next_state = ST_LOAD_TAPS;
            default:                      w_next_state = ST_LOAD_TAPS;
        endcase
    end

    // Status outputs are registered from the next state so they track the state register.
    always_comb begin
        w_cap_taps     = 1'b0;
        w_cap_seed     = 1'b0;
        w_cap_count    = 1'b0;
        w_load_err_nxt = 1'b0;
        w_start_nxt    = 1'b0;
        w_phase_nxt    = phase_of(w_next_state);
        if (w_accept) begin
            w_cap_taps  = (r_state == ST_LOAD_TAPS);
            w_cap_seed  = (r_state == ST_LOAD_SEED);
            w_cap_count = (r_state == ST_LOAD_COUNT);
        end
        if (w_press && w_in_load && (r_sw_s == '0)) begin
            w_load_err_nxt = 1'b1;
        end
        if (w_next_state == ST_FIRE) begin
            w_start_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_taps     <= '0;
            r_seed     <= '0;
            r_seq_num  <= '0;
            r_start    <= 1'b0;
            r_load_err <= 1'b0;
            r_phase    <= PH_TAPS;
        end else begin
            if (w_cap_taps)  r_taps    <= r_sw_s;
            if (w_cap_seed)  r_seed    <= r_sw_s;
            if (w_cap_count) r_seq_num <= r_sw_s;
            r_start    <= w_start_nxt;
            r_load_err <= w_load_err_nxt;
            r_phase    <= w_phase_nxt;
        end
    end

    assign bus.start    = r_start;
    assign bus.taps     = r_taps;
    assign bus.seed     = r_seed;
    assign bus.seq_num  = r_seq_num;
    assign bus.phase    = r_phase;
    assign bus.load_err = r_load_err;

endmodule
